// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : 640x480@60 pixel-timing generator with render-latency
//                aligned sync/blanking output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        frame_start,
    input  logic [11:0] rgb_in,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    // Timing landmarks in counter width so every compare is 10-bit.
    localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
    localparam logic [9:0] c_h_sync_s = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_h_sync_e = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_h_last   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
    localparam logic [9:0] c_v_sync_s = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_v_sync_e = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_frame_start;
    logic        r_hsync;
    logic        r_vsync;
    logic [11:0] r_rgb;

    logic        w_de;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [2:0]  w_dly;     // {de, hs, vs} aligned with the returning colour

    // Horizontal/vertical position counters, advanced only on pixel ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_en) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
                if (r_v_cnt == c_v_last) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + 10'd1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // Raw (undelayed) timing decodes of the current counter position.
    assign w_de     = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    assign w_hs_raw = (r_h_cnt >= c_h_sync_s) && (r_h_cnt < c_h_sync_e);
    assign w_vs_raw = (r_v_cnt >= c_v_sync_s) && (r_v_cnt < c_v_sync_e);

    generate
        if (PIPE_DLY == 0) begin : g_bypass
            // Render returns colour combinationally; no alignment needed.
            assign w_dly = {w_de, w_hs_raw, w_vs_raw};
        end else begin : g_pipe
            logic [2:0] r_stage [PIPE_DLY];

            // Shift timing flags along with the render pipeline, one stage per tick.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        r_stage[i] <= '0;
                    end
                end else if (pix_en) begin
                    r_stage[0] <= {w_de, w_hs_raw, w_vs_raw};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign w_dly = r_stage[PIPE_DLY-1];
        end
    endgenerate

    // Pin register: polarity-adjusted sync and blanked colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_rgb   <= 12'h000;
        end else if (pix_en) begin
            r_hsync <= w_dly[1] ~^ SYNC_POL;
            r_vsync <= w_dly[0] ~^ SYNC_POL;
            r_rgb   <= w_dly[2] ? rgb_in : 12'h000;
        end
    end

    // One-clk pulse following the tick that wraps the counters to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pix_en && (r_h_cnt == c_h_last) && (r_v_cnt == c_v_last);
        end
    end

    assign x           = r_h_cnt;
    assign y           = r_v_cnt;
    assign de          = w_de;
    assign frame_start = r_frame_start;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign r           = r_rgb[11:8];
    assign g           = r_rgb[7:4];
    assign b           = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Scoreboard bench for vga_sync_gen. A full-size instance
//                covers line timing, stalls and colour alignment; a reduced
//                geometry instance covers frame-level timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    localparam int S_X   = 0;
    localparam int S_Y   = 1;
    localparam int S_HS  = 2;
    localparam int S_VS  = 3;
    localparam int S_RGB = 4;
    localparam int S_FS  = 5;
    localparam int S_DE  = 6;
    localparam int S_XS  = 7;
    localparam int S_YS  = 8;
    localparam int S_RGBS = 9;
    localparam int S_DES = 10;
    localparam int S_FSS = 11;
    localparam int S_MEAS = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        pix_en;
    logic        started;

    logic [9:0]  x, y, xs, ys;
    logic        de, des, frame_start, fss;
    logic [11:0] rgb_in;
    logic        hsync, vsync, hss, vss;
    logic [3:0]  r, g, b, rs, gs, bs;

    vga_sync_gen dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .de(de),
        .frame_start(frame_start), .rgb_in(rgb_in), .hsync(hsync),
        .vsync(vsync), .r(r), .g(g), .b(b)
    );

    // Reduced geometry: 30 ticks per line, 15 lines, 450 ticks per frame.
    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(xs), .y(ys), .de(des),
        .frame_start(fss), .rgb_in(12'hFFF), .hsync(hss),
        .vsync(vss), .r(rs), .g(gs), .b(bs)
    );

    // Render stand-in: colour of the presented pixel, two ticks later.
    logic [11:0] rnd_p1, rnd_p2;
    always @(posedge clk) begin
        if (pix_en) begin
            rnd_p1 <= (x < 10'd640 && y < 10'd480) ? {x[3:0], y[3:0], 4'hA} : 12'hFFF;
            rnd_p2 <= rnd_p1;
        end
    end
    assign rgb_in = rnd_p2;

    // Bench's own tick count since reset release.
    int tk = 0;
    always @(posedge clk) begin
        if (rst) tk <= 0;
        else if (pix_en) tk <= tk + 1;
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
        logic [31:0] meas;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_sig(input string n, input int s, input logic [31:0] e);
        sb.push_back('{name: n, sel: s, exp: e, meas: 32'd0});
    endtask

    task automatic expect_meas(input string n, input logic [31:0] m, input logic [31:0] e);
        sb.push_back('{name: n, sel: S_MEAS, exp: e, meas: m});
    endtask

    task automatic check_now(input string n, input logic [31:0] act, input logic [31:0] e);
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", n, act, e);
    endtask

    initial begin : monitor
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                c = sb.pop_front();
                case (c.sel)
                    S_X:    act = 32'(x);
                    S_Y:    act = 32'(y);
                    S_HS:   act = 32'(hsync);
                    S_VS:   act = 32'(vsync);
                    S_RGB:  act = 32'({r, g, b});
                    S_FS:   act = 32'(frame_start);
                    S_DE:   act = 32'(de);
                    S_XS:   act = 32'(xs);
                    S_YS:   act = 32'(ys);
                    S_RGBS: act = 32'({rs, gs, bs});
                    S_DES:  act = 32'(des);
                    S_FSS:  act = 32'(fss);
                    default: act = c.meas;
                endcase
                n_checks++;
                if (act === c.exp) n_pass++;
                else $display("FAIL %s: actual 0x%0h required 0x%0h", c.name, act, c.exp);
            end
        end
    end

    initial begin : watchdog
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

    // ------------------------------------------------------------------
    // Continuous pin model for the full-size instance: pins show pixel tk-3.
    // ------------------------------------------------------------------
    int pin_errs = 0;
    initial begin : pin_model
        int          p, px, py;
        logic [11:0] e_rgb;
        logic        e_hs, e_vs;
        forever begin
            @(negedge clk);
            if (started && !rst) begin
                if (tk < 3) begin
                    e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
                end else begin
                    p  = tk - 3;
                    px = p % 800;
                    py = (p / 800) % 525;
                    e_hs  = !(px >= 656 && px < 752);
                    e_vs  = !(py >= 490 && py < 492);
                    e_rgb = (px < 640 && py < 480) ? {4'(px), 4'(py), 4'hA} : 12'h000;
                end
                if (hsync !== e_hs || vsync !== e_vs || {r, g, b} !== e_rgb)
                    pin_errs++;
            end
        end
    end

    // Line-timing measurements (full-size instance).
    int   x656_tk = -1, hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1;
    logic hs_prev = 1'b1;
    always @(negedge clk) begin
        if (started && !rst) begin
            if (x == 10'd656 && x656_tk < 0) x656_tk <= tk;
            if (hs_prev && !hsync) begin
                if (hs_fall1 < 0) hs_fall1 <= tk;
                else if (hs_fall2 < 0) hs_fall2 <= tk;
            end
            if (!hs_prev && hsync && hs_rise1 < 0) hs_rise1 <= tk;
            hs_prev <= hsync;
        end
    end

    // Frame-timing measurements (reduced instance) and stray pulse count.
    int   vs_fall1 = -1, vs_rise1 = -1, fs1 = -1, fs2 = -1;
    int   fs_run = 0, fs_run_max = 0, fs_cnt_def = 0;
    logic vs_prev = 1'b1;
    always @(negedge clk) begin
        if (started && !rst) begin
            if (vs_prev && !vss && vs_fall1 < 0) vs_fall1 <= tk;
            if (!vs_prev && vss && vs_rise1 < 0) vs_rise1 <= tk;
            vs_prev <= vss;
            if (fss) begin
                fs_run <= fs_run + 1;
                if (fs_run + 1 > fs_run_max) fs_run_max <= fs_run + 1;
                if (fs_run == 0) begin
                    if (fs1 < 0) fs1 <= tk;
                    else if (fs2 < 0) fs2 <= tk;
                end
            end else begin
                fs_run <= 0;
            end
            if (frame_start) fs_cnt_def <= fs_cnt_def + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input logic pe);
        pix_en = pe;
        @(posedge clk);
        #1;
    endtask

    // Pixel enable on every second clock until the bench tick count hits target.
    task automatic advance(input int target);
        int guard;
        guard = 0;
        while (tk < target) begin
            step(1'b1);
            step(1'b0);
            guard++;
            if (guard > 20000) begin
                check_now("advance_wait_expired", 32'(tk), 32'(target));
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; started = 1'b0;
        step(1'b1); step(1'b0); step(1'b1);
        check_now("rst_now_x", 32'(x), 0);
        check_now("rst_now_y", 32'(y), 0);
        check_now("rst_now_hsync", 32'(hsync), 1);
        check_now("rst_now_vsync", 32'(vsync), 1);
        check_now("rst_now_rgb", 32'({r, g, b}), 0);
        check_now("rst_now_frame_start", 32'(frame_start), 0);
        expect_sig("rst_x", S_X, 0);
        expect_sig("rst_y", S_Y, 0);
        expect_sig("rst_hsync", S_HS, 1);
        expect_sig("rst_vsync", S_VS, 1);
        expect_sig("rst_rgb", S_RGB, 0);
        expect_sig("rst_frame_start", S_FS, 0);
        expect_sig("rst_de", S_DE, 1);
        expect_sig("rst_small_x", S_XS, 0);

        rst = 1'b0; started = 1'b1;
        step(1'b1);
        expect_sig("first_tick_x", S_X, 1);
        expect_sig("first_tick_y", S_Y, 0);
        expect_sig("first_tick_rgb", S_RGB, 0);
        step(1'b0);

        // Stall at (300,2): pins show pixel (297,2).
        advance(1900);
        expect_sig("stall_x", S_X, 300);
        expect_sig("stall_y", S_Y, 2);
        expect_sig("stall_rgb", S_RGB, 12'h92A);
        expect_sig("stall_hsync", S_HS, 1);
        for (int i = 0; i < 100; i++) step(1'b0);
        expect_sig("stall_hold_x", S_X, 300);
        expect_sig("stall_hold_y", S_Y, 2);
        expect_sig("stall_hold_rgb", S_RGB, 12'h92A);
        step(1'b1);
        expect_sig("resume_x", S_X, 301);
        expect_sig("resume_rgb", S_RGB, 12'hA2A);
        step(1'b0);

        expect_meas("hs_fall_after_x656", 32'(hs_fall1 - x656_tk), 3);
        expect_meas("hs_first_fall_tick", 32'(hs_fall1), 659);
        expect_meas("hs_low_ticks", 32'(hs_rise1 - hs_fall1), 96);
        expect_meas("hs_fall_period", 32'(hs_fall2 - hs_fall1), 800);
        expect_meas("small_vs_first_fall", 32'(vs_fall1), 303);
        expect_meas("small_vs_low_ticks", 32'(vs_rise1 - vs_fall1), 60);
        expect_meas("small_fs_first_tick", 32'(fs1), 450);
        expect_meas("small_fs_period", 32'(fs2 - fs1), 450);
        expect_meas("small_fs_width_clks", 32'(fs_run_max), 1);

        // Colour alignment and blanking edges on line 7.
        advance(5608);
        expect_sig("pixel_5_7_rgb", S_RGB, 12'h57A);
        advance(6242);
        expect_sig("pixel_639_7_rgb", S_RGB, 12'hF7A);
        advance(6243);
        expect_sig("pixel_640_7_blank", S_RGB, 12'h000);
        advance(6303);
        expect_sig("pixel_700_7_blank", S_RGB, 12'h000);
        expect_sig("pixel_700_7_hsync", S_HS, 0);

        // Mid-frame reset at (400,8) with the delay line full.
        advance(6800);
        expect_sig("pre_rst_x", S_X, 400);
        expect_sig("pre_rst_rgb", S_RGB, 12'hD8A);
        rst = 1'b1;
        step(1'b1);
        expect_sig("mid_rst_x", S_X, 0);
        expect_sig("mid_rst_y", S_Y, 0);
        expect_sig("mid_rst_hsync", S_HS, 1);
        expect_sig("mid_rst_vsync", S_VS, 1);
        expect_sig("mid_rst_rgb", S_RGB, 0);
        expect_sig("mid_rst_frame_start", S_FS, 0);
        expect_sig("mid_rst_small_y", S_YS, 0);
        expect_sig("mid_rst_small_fs", S_FSS, 0);
        rst = 1'b0;
        step(1'b0);
        step(1'b1);
        expect_sig("post_rst_x", S_X, 1);
        step(1'b0);

        advance(6);
        expect_sig("small_active_rgb", S_RGBS, 12'hFFF);
        expect_sig("small_active_de", S_DES, 1);
        advance(20);
        expect_sig("small_blank_rgb", S_RGBS, 12'h000);
        expect_sig("small_blank_de", S_DES, 0);
        step(1'b0);

        @(negedge clk);
        #1;
        expect_meas("pin_model_errors", 32'(pin_errs), 0);
        expect_meas("full_size_frame_start_count", 32'(fs_cnt_def), 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
